// File: rtl/GateLevel4BitAdder.sv
// rtl/GateLevel4BitAdder.sv - 4-bit gate-level ripple-carry adder slice
module GateLevel4BitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;
  logic [3:0] p;
  logic [3:0] g;

  assign c[0] = cin;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_fa
      assign p[k]   = a[k] ^ b[k];
      assign g[k]   = a[k] & b[k];
      assign s[k]   = p[k] ^ c[k];
      assign c[k+1] = g[k] | (p[k] & c[k]);
    end
  endgenerate

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - nibble-serial adder sequencer; optional NSA_SIGNED_OVERFLOW_EN adds overflow output
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
`ifdef NSA_SIGNED_OVERFLOW_EN
  ,
  output logic                 overflow
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
`ifdef NSA_SIGNED_OVERFLOW_EN
  logic           ovf_q, ovf_d;
  logic           msb_carry_in;
`endif

  logic [3:0]     slice_a;
  logic [3:0]     slice_b;
  logic [3:0]     slice_s;
  logic           slice_cout;

  // Route the nibble selected by the current index into the slice
  always_comb begin
    slice_a = 4'h0;
    slice_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        slice_a = op_a_q[4*i +: 4];
        slice_b = op_b_q[4*i +: 4];
      end
    end
  end

  GateLevel4BitAdder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

`ifdef NSA_SIGNED_OVERFLOW_EN
  // Carry into the MSB recovered from the MSB sum bit, since the slice hides it
  assign msb_carry_in = op_a_q[W-1] ^ op_b_q[W-1] ^ slice_s[3];
`endif

  // Next-state and next-output computation for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef NSA_SIGNED_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_a_d     = a;
          op_b_d     = b;
          carry_d    = cin;
          idx_d      = '0;
          sum_d      = '0;
          cout_d     = 1'b0;
`ifdef NSA_SIGNED_OVERFLOW_EN
          ovf_d      = 1'b0;
`endif
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[4*i +: 4] = slice_s;
          end
        end
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d      = slice_cout;
`ifdef NSA_SIGNED_OVERFLOW_EN
          ovf_d       = msb_carry_in ^ slice_cout;
`endif
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // in_ready only returns the cycle after the output handshake
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // All sequencer state and registered outputs; reset discards any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NSA_SIGNED_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef NSA_SIGNED_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NSA_SIGNED_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - self-checking bench for nibble_serial_adder_ctrl with arithmetic reference model
module tb_nibble_serial_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NSA_SIGNED_OVERFLOW_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int           cyc;
  int           seen;
  int           t_first;
  int           stale;
  logic [W:0]   e;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NSA_SIGNED_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = model_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int waited;
    waited   = 0;
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    check_eq("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    check_eq("busy_after_accept", in_ready, 0);
  endtask

  task automatic wait_result(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int         lat;
    logic [W:0] ex;
    ex  = model_add(ta, tb, tc);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check_eq("latency", lat, NIB);
    check_eq("sum", sum, ex[W-1:0]);
    check_eq("cout", cout, ex[W]);
`ifdef NSA_SIGNED_OVERFLOW_EN
    check_eq("overflow", overflow, model_ovf(ta, tb, tc));
`endif
  endtask

  task automatic release_out(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int hold);
    logic [W:0] ex;
    ex = model_add(ta, tb, tc);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("hold_sum", sum, ex[W-1:0]);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_not_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("valid_drop", out_valid, 0);
    check_eq("ready_back", in_ready, 1);
  endtask

  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int hold);
    send(ta, tb, tc);
    wait_result(ta, tb, tc);
    release_out(ta, tb, tc, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
`ifdef NSA_SIGNED_OVERFLOW_EN
    check_eq("rst_overflow", overflow, 0);
`endif
    #10;
    rst_n = 1'b1;
    step();

    // Directed vectors
    txn(16'h0001, 16'hFFFF, 1'b0, 0);
    txn(16'h1234, 16'h4321, 1'b0, 1);
    txn(16'hFFFF, 16'h0000, 1'b1, 0);

    // Backpressure in DONE with new operands offered
    send(16'h0F0F, 16'h0000, 1'b0);
    wait_result(16'h0F0F, 16'h0000, 1'b0);
    e         = model_add(16'h0F0F, 16'h0000, 1'b0);
    a         = 16'h0F0F;
    b         = 16'h0101;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_sum", sum, e[W-1:0]);
      check_eq("bp_cout", cout, e[W]);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_idle_ready", in_ready, 1);
    send(16'h0F0F, 16'h0101, 1'b0);
    wait_result(16'h0F0F, 16'h0101, 1'b0);
    check_eq("bp_sum_1010", sum, 16'h1010);
    release_out(16'h0F0F, 16'h0101, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high
    a         = 16'h00FF;
    b         = 16'h0001;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    seen      = 0;
    t_first   = 0;
    while (seen < 2 && cyc < 40) begin
      step();
      cyc++;
      if (!in_ready && seen == 0) begin
        a = 16'h8000;
        b = 16'h8000;
      end
      if (out_valid) begin
        if (seen == 0) begin
          e = model_add(16'h00FF, 16'h0001, 1'b0);
          check_eq("b2b0_sum", sum, e[W-1:0]);
          check_eq("b2b0_cout", cout, e[W]);
          t_first = cyc;
        end else begin
          e = model_add(16'h8000, 16'h8000, 1'b0);
          check_eq("b2b1_sum", sum, e[W-1:0]);
          check_eq("b2b1_cout", cout, e[W]);
          check_eq("b2b_spacing", cyc - t_first, NIB + 2);
          in_valid = 1'b0;
        end
        seen++;
      end
    end
    check_eq("b2b_count", seen, 2);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check_eq("b2b_idle_ready", in_ready, 1);
    check_eq("b2b_idle_valid", out_valid, 0);

    // Reset in the middle of RUN after two nibbles
    send(16'hAAAA, 16'h5555, 1'b0);
    step();
    step();
    e = model_add(16'hAAAA, 16'h5555, 1'b0);
    check_eq("partial_sum", sum, {8'h00, e[7:0]});
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_sum", sum, 0);
    check_eq("mrst_cout", cout, 0);
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_in_ready", in_ready, 1);
    #3;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) stale++;
    end
    check_eq("no_stale_valid", stale, 0);
    check_eq("post_rst_ready", in_ready, 1);

`ifdef NSA_SIGNED_OVERFLOW_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_result(16'h7FFF, 16'h0001, 1'b0);
    check_eq("ovf_pos_sum", sum, 16'h8000);
    check_eq("ovf_pos_flag", overflow, 1);
    check_eq("ovf_pos_cout", cout, 0);
    release_out(16'h7FFF, 16'h0001, 1'b0, 0);
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_result(16'hFFFF, 16'h0001, 1'b0);
    check_eq("ovf_neg_flag", overflow, 0);
    check_eq("ovf_neg_cout", cout, 1);
    release_out(16'hFFFF, 16'h0001, 1'b0, 0);
`endif

    // Randomized transactions against the arithmetic model
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      txn(ra, rb, rc, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
